// File: rtl/spike_frame_sequencer_if.sv
// Sample-in / result-out handshake bundle between the frame sequencer, its sample
// producer, the spiking layer and the result consumer. The sequencer uses the slave modport.
interface spike_frame_sequencer_if #(
  parameter int NUM_SPIKES = 16,
  parameter int TIME_W     = 4,
  parameter int NEURON_W   = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_training;
  logic [NUM_SPIKES*TIME_W-1:0] in_spike_times;
  logic [NUM_SPIKES*TIME_W-1:0] spike_times;
  logic                         training;
  logic [TIME_W-1:0]            time_val;
  logic                         frame_start;
  logic [NEURON_W-1:0]          winning_neuron;
  logic                         res_valid;
  logic                         res_ready;
  logic [NEURON_W-1:0]          res_neuron;

  modport slave (
    input  in_valid, in_training, in_spike_times, winning_neuron, res_ready,
    output in_ready, spike_times, training, time_val, frame_start, res_valid, res_neuron
  );

  modport master (
    output in_valid, in_training, in_spike_times, winning_neuron, res_ready,
    input  in_ready, spike_times, training, time_val, frame_start, res_valid, res_neuron
  );
endinterface

// File: rtl/spike_frame_sequencer.sv
// Frame time-base for the clocked-STDP layer: holds one spike vector per frame, counts ticks,
// captures the winner in test frames. Optional FRAME_COUNT_EN adds saturating per-mode frame counters.
module spike_frame_sequencer #(
  parameter int NUM_SPIKES   = 16,
  parameter int TIME_W       = 4,
  parameter int TRAIN_PERIOD = 16,
  parameter int TEST_PERIOD  = 8,
  parameter int CAPTURE_T    = 6,
  parameter int NEURON_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_l,
`ifdef FRAME_COUNT_EN
  output logic [15:0]           train_frames,
  output logic [15:0]           test_frames,
`endif
  spike_frame_sequencer_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [TIME_W-1:0] TRAIN_LAST = TIME_W'(TRAIN_PERIOD - 1);
  localparam logic [TIME_W-1:0] TEST_LAST  = TIME_W'(TEST_PERIOD - 1);
  localparam logic [TIME_W-1:0] CAP_TICK   = TIME_W'(CAPTURE_T);

  state_t                       state_q, state_d;
  logic [TIME_W-1:0]            time_q, time_d;
  logic [NUM_SPIKES*TIME_W-1:0] spikes_q, spikes_d;
  logic                         training_q, training_d;
  logic                         frame_start_q, frame_start_d;
  logic                         res_valid_q, res_valid_d;
  logic [NEURON_W-1:0]          res_neuron_q, res_neuron_d;

  logic [TIME_W-1:0] last_tick;
  logic              frame_end;
  logic              in_ready_w;
  logic              accept;
  logic              capture;

  assign last_tick  = training_q ? TRAIN_LAST : TEST_LAST;
  assign frame_end  = (state_q == RUN) && (time_q == last_tick);
  // An unconsumed result blocks the next frame; a same-cycle res_ready frees it.
  assign in_ready_w = ((state_q == IDLE) || frame_end) && !(res_valid_q && !bus.res_ready);
  assign accept     = bus.in_valid && in_ready_w;
  assign capture    = (state_q == RUN) && !training_q && (time_q == CAP_TICK);

`ifdef FRAME_COUNT_EN
  logic [15:0] train_cnt_q, train_cnt_d;
  logic [15:0] test_cnt_q, test_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    time_d        = time_q;
    spikes_d      = spikes_q;
    training_d    = training_q;
    frame_start_d = 1'b0;
    res_valid_d   = res_valid_q;
    res_neuron_d  = res_neuron_q;
`ifdef FRAME_COUNT_EN
    train_cnt_d   = train_cnt_q;
    test_cnt_d    = test_cnt_q;
`endif

    case (state_q)
      RUN: begin
        if (!frame_end) begin
          time_d = time_q + TIME_W'(1);
        end else if (!accept) begin
          state_d = IDLE;
          time_d  = '0;
        end
      end
      default: ;
    endcase

    // Covers both a start from IDLE and a back-to-back start on the last tick.
    if (accept) begin
      state_d       = RUN;
      time_d        = '0;
      spikes_d      = bus.in_spike_times;
      training_d    = bus.in_training;
      frame_start_d = 1'b1;
`ifdef FRAME_COUNT_EN
      if (bus.in_training && (train_cnt_q != 16'hFFFF)) train_cnt_d = train_cnt_q + 16'd1;
      if (!bus.in_training && (test_cnt_q != 16'hFFFF)) test_cnt_d = test_cnt_q + 16'd1;
`endif
    end

    if (capture) begin
      res_valid_d  = 1'b1;
      res_neuron_d = bus.winning_neuron;
    end else if (bus.res_ready) begin
      res_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= IDLE;
      time_q        <= '0;
      spikes_q      <= '0;
      training_q    <= 1'b0;
      frame_start_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_neuron_q  <= '0;
`ifdef FRAME_COUNT_EN
      train_cnt_q   <= '0;
      test_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      time_q        <= time_d;
      spikes_q      <= spikes_d;
      training_q    <= training_d;
      frame_start_q <= frame_start_d;
      res_valid_q   <= res_valid_d;
      res_neuron_q  <= res_neuron_d;
`ifdef FRAME_COUNT_EN
      train_cnt_q   <= train_cnt_d;
      test_cnt_q    <= test_cnt_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.spike_times = spikes_q;
  assign bus.training    = training_q;
  assign bus.time_val    = time_q;
  assign bus.frame_start = frame_start_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_neuron  = res_neuron_q;
`ifdef FRAME_COUNT_EN
  assign train_frames    = train_cnt_q;
  assign test_frames     = test_cnt_q;
`endif

endmodule

// File: tb/tb_spike_frame_sequencer.sv
// Bench for spike_frame_sequencer: directed steps plus a random phase, checked against a
// frame-level model (active flag, tick count, latched mode/vector, expected-result queue).
module tb_spike_frame_sequencer;
  localparam int NS = 16, TW = 4, NW = 4, TRAIN_P = 16, TEST_P = 8, CAP_T = 6;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  spike_frame_sequencer_if #(.NUM_SPIKES(NS), .TIME_W(TW), .NEURON_W(NW)) bus ();
`ifdef FRAME_COUNT_EN
  logic [15:0] train_frames, test_frames;
`endif

  spike_frame_sequencer #(
    .NUM_SPIKES(NS), .TIME_W(TW), .TRAIN_PERIOD(TRAIN_P),
    .TEST_PERIOD(TEST_P), .CAPTURE_T(CAP_T), .NEURON_W(NW)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
`ifdef FRAME_COUNT_EN
    .train_frames(train_frames),
    .test_frames(test_frames),
`endif
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit               m_active, m_mode, m_fs, m_res_v;
  int               m_tick;
  logic [NS*TW-1:0] m_vec;
  logic [NW-1:0]    m_res_n;
  logic [NW-1:0]    res_q[$];
  int               m_train_cnt, m_test_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int period(input bit mode);
    return mode ? TRAIN_P : TEST_P;
  endfunction

  function automatic bit exp_ready();
    return (!m_active || (m_tick == period(m_mode) - 1)) && !(m_res_v && !bus.res_ready);
  endfunction

  task automatic reset_model();
    m_active = 0; m_mode = 0; m_fs = 0; m_res_v = 0; m_tick = 0;
    m_vec = '0; m_res_n = '0; res_q.delete();
    m_train_cnt = 0; m_test_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("time_val", bus.time_val, m_tick);
    chk("frame_start", bus.frame_start, m_fs);
    chk("training", bus.training, m_mode);
    chk("spike_times", bus.spike_times, m_vec);
    chk("res_valid", bus.res_valid, m_res_v);
    chk("res_neuron", bus.res_neuron, m_res_n);
`ifdef FRAME_COUNT_EN
    chk("train_frames", train_frames, m_train_cnt);
    chk("test_frames", test_frames, m_test_cnt);
`endif
  endtask

  // Drives winning_neuron: 'fixed' (or random if negative) on the capture tick, 2 elsewhere.
  task automatic drive_win(input int fixed);
    if (m_active && !m_mode && m_tick == CAP_T)
      bus.winning_neuron = (fixed >= 0) ? NW'(fixed) : NW'($urandom_range(0, 15));
    else
      bus.winning_neuron = NW'(2);
  endtask

  // One clock: check in_ready before the edge, advance the model at the edge, check after.
  task automatic cycle(output bit acc);
    bit            rdy, cap;
    logic [NW-1:0] win;
    #1;
    rdy = exp_ready();
    chk("in_ready", bus.in_ready, rdy);
    acc = bus.in_valid && rdy;
    cap = m_active && !m_mode && (m_tick == CAP_T);
    win = bus.winning_neuron;
    if (m_res_v && bus.res_ready) begin
      if (res_q.size() == 0) chk("res_pending", res_q.size(), 1);
      else chk("res_order", bus.res_neuron, res_q.pop_front());
    end
    @(posedge clk);
    if (cap) begin
      m_res_v = 1; m_res_n = win; res_q.push_back(win);
    end else if (bus.res_ready) begin
      m_res_v = 0;
    end
    if (acc) begin
      m_active = 1; m_tick = 0; m_mode = bus.in_training; m_vec = bus.in_spike_times; m_fs = 1;
      if (bus.in_training) begin if (m_train_cnt < 65535) m_train_cnt++; end
      else begin if (m_test_cnt < 65535) m_test_cnt++; end
    end else begin
      m_fs = 0;
      if (m_active) begin
        if (m_tick == period(m_mode) - 1) begin m_active = 0; m_tick = 0; end
        else m_tick++;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n, input int fixed);
    bit acc;
    for (int k = 0; k < n; k++) begin
      drive_win(fixed);
      cycle(acc);
    end
  endtask

  // Offers a frame until accepted (bounded), then runs to its last tick with in_valid low.
  task automatic run_frame(input bit mode, input logic [NS*TW-1:0] vec, input int fixed);
    bit acc;
    int waited;
    acc = 0;
    waited = 0;
    bus.in_valid = 1; bus.in_training = mode; bus.in_spike_times = vec;
    while (!acc && waited < 40) begin
      drive_win(fixed);
      cycle(acc);
      waited++;
    end
    if (!acc) chk("accept_timeout", waited, 0);
    bus.in_valid = 0;
    bus.in_training = ~mode;
    idle_cycles(period(mode) - 1, fixed);
  endtask

  initial begin
    bit acc;
    logic [NS*TW-1:0] vec3;
    for (int c = 0; c < NS; c++) vec3[c*TW +: TW] = TW'(3);

    bus.in_valid = 0; bus.in_training = 0; bus.in_spike_times = '0;
    bus.winning_neuron = '0; bus.res_ready = 0;
    reset_model();

    // Reset values
    #12;
    chk("rst_time_val", bus.time_val, 0);
    chk("rst_spike_times", bus.spike_times, 0);
    chk("rst_training", bus.training, 0);
    chk("rst_frame_start", bus.frame_start, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_neuron", bus.res_neuron, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_l = 1;

    // Training frame, all channels 3: no result expected
    run_frame(1'b1, vec3, -1);
    idle_cycles(3, -1);
    chk("train_no_result", bus.res_valid, 0);

    // Test frame: winner 9 at the capture tick
    run_frame(1'b0, {$urandom, $urandom}, 9);
    idle_cycles(1, 9);
    chk("res_valid_after_test", bus.res_valid, 1);
    chk("res_neuron_9", bus.res_neuron, 9);
    bus.res_ready = 1;
    idle_cycles(1, -1);

    // Three back-to-back test frames, results taken immediately
    for (int f = 0; f < 3; f++) run_frame(1'b0, {$urandom, $urandom}, -1);
    idle_cycles(2, -1);
    chk("b2b_results_drained", res_q.size(), 0);

    // Unconsumed result blocks the next frame until res_ready rises
    bus.res_ready = 0;
    run_frame(1'b0, {$urandom, $urandom}, 5);
    chk("ready_blocked", bus.in_ready, 0);
    bus.in_valid = 1; bus.in_training = 0; bus.in_spike_times = {$urandom, $urandom};
    idle_cycles(3, -1);
    chk("still_idle", bus.time_val, 0);
    bus.res_ready = 1;
    drive_win(-1);
    cycle(acc);
    chk("accept_on_release", acc, 1);
    bus.in_valid = 0;
    idle_cycles(TEST_P + 1, -1);

    // Random phase: mid-frame mode flips, withdrawn offers, random res_ready
    for (int i = 0; i < 300; i++) begin
      bus.in_valid       = ($urandom_range(0, 3) != 0);
      bus.in_training    = 1'($urandom_range(0, 1));
      bus.in_spike_times = {$urandom, $urandom};
      bus.winning_neuron = NW'($urandom_range(0, 15));
      bus.res_ready      = ($urandom_range(0, 2) != 0);
      cycle(acc);
    end
    bus.in_valid = 0; bus.res_ready = 1;
    idle_cycles(TRAIN_P + 2, -1);

    // Asynchronous reset at tick 4 of a training frame
    run_frame(1'b1, vec3, -1);
    chk("pre_reset_tick", bus.time_val, TRAIN_P - 1);
    bus.in_valid = 1; bus.in_training = 1; bus.in_spike_times = {$urandom, $urandom};
    idle_cycles(1, -1);
    bus.in_valid = 0;
    idle_cycles(4, -1);
    chk("at_tick4", bus.time_val, 4);
    #2 rst_l = 0;
    #1;
    chk("arst_time_val", bus.time_val, 0);
    chk("arst_spike_times", bus.spike_times, 0);
    chk("arst_training", bus.training, 0);
    chk("arst_frame_start", bus.frame_start, 0);
    chk("arst_res_valid", bus.res_valid, 0);
    chk("arst_res_neuron", bus.res_neuron, 0);
    reset_model();
    @(negedge clk);
    rst_l = 1;

    // After reset: 2 training frames then 3 test frames
    run_frame(1'b1, vec3, -1);
    run_frame(1'b1, {$urandom, $urandom}, -1);
    for (int f = 0; f < 3; f++) run_frame(1'b0, {$urandom, $urandom}, -1);
    idle_cycles(3, -1);
`ifdef FRAME_COUNT_EN
    chk("train_frames_2", train_frames, 2);
    chk("test_frames_3", test_frames, 3);
`endif
    chk("final_idle_ready", bus.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
